// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } mem_state_t;

    // Data memory is word addressed; low address bits are dropped on requests.
    localparam int unsigned ADDR_ALIGN_BITS = 2;

endpackage

// File: rtl/mem_stage_wdog.sv
// Watchdog for an outstanding memory transaction; flags expiry after TIMEOUT
// consecutive unacknowledged BUSY cycles.
module mem_stage_wdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic busy,
    input  logic ack,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q;
    logic            counting;

    assign counting = busy && !ack;
    assign expired  = counting && (cnt_q == LastCnt);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear || !busy) begin
            cnt_q <= '0;
        end else if (counting) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: req/ack handshake to a variable-latency data memory
// and registered results to write-back. Watchdog abort enabled by MEM_STAGE_TIMEOUT_EN.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_mem_read,
    input  logic         in_mem_write,
    input  logic         in_wd_selector,
    input  logic [N-1:0] in_alu_result,
    input  logic [N-1:0] in_write_data,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic         out_valid,
    output logic         out_wd_selector,
    output logic [N-1:0] out_read_data,
    output logic [N-1:0] out_alu_result,
    output logic         err
);

    mem_state_t state_q, state_d;

    logic         mem_req_d, mem_we_d;
    logic [N-1:0] mem_addr_d, mem_wdata_d;
    logic         out_valid_d, out_wd_d;
    logic [N-1:0] out_rd_d, out_alu_d;

    // Write-back fields of the instruction currently in memory.
    logic         pend_wd_q, pend_wd_d;
    logic [N-1:0] pend_alu_q, pend_alu_d;

    // Holds a non-memory instruction accepted in the same cycle a memory
    // instruction completes, so each out_valid pulse carries one instruction.
    logic         skid_valid_q, skid_valid_d;
    logic         skid_wd_q, skid_wd_d;
    logic [N-1:0] skid_alu_q, skid_alu_d;

    logic ack_ok, accept, is_mem, timeout, finish;

    assign stall  = (state_q == BUSY) && !mem_ack;
    assign ack_ok = (state_q == BUSY) && mem_ack;
    assign accept = in_valid && !stall;
    assign is_mem = in_mem_read || in_mem_write;
    assign finish = ack_ok || timeout;

`ifdef MEM_STAGE_TIMEOUT_EN
    mem_stage_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept && is_mem),
        .busy    (state_q == BUSY),
        .ack     (mem_ack),
        .expired (timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        out_valid_d  = 1'b0;
        out_wd_d     = out_wd_selector;
        out_rd_d     = out_read_data;
        out_alu_d    = out_alu_result;
        pend_wd_d    = pend_wd_q;
        pend_alu_d   = pend_alu_q;
        skid_valid_d = 1'b0;
        skid_wd_d    = skid_wd_q;
        skid_alu_d   = skid_alu_q;

        if (finish) begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
            out_valid_d = 1'b1;
            out_wd_d    = pend_wd_q;
            out_alu_d   = pend_alu_q;
            if (timeout) begin
                out_rd_d = '0;
            end else if (!mem_we) begin
                out_rd_d = mem_rdata;
            end
        end else if (skid_valid_q) begin
            out_valid_d = 1'b1;
            out_wd_d    = skid_wd_q;
            out_alu_d   = skid_alu_q;
        end

        if (accept) begin
            if (is_mem) begin
                state_d     = BUSY;
                mem_req_d   = 1'b1;
                mem_we_d    = in_mem_write;
                mem_addr_d  = {in_alu_result[N-1:ADDR_ALIGN_BITS], {ADDR_ALIGN_BITS{1'b0}}};
                mem_wdata_d = in_write_data;
                pend_wd_d   = in_wd_selector;
                pend_alu_d  = in_alu_result;
            end else if (out_valid_d) begin
                skid_valid_d = 1'b1;
                skid_wd_d    = in_wd_selector;
                skid_alu_d   = in_alu_result;
            end else begin
                out_valid_d = 1'b1;
                out_wd_d    = in_wd_selector;
                out_alu_d   = in_alu_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            out_valid       <= 1'b0;
            out_wd_selector <= 1'b0;
            out_read_data   <= '0;
            out_alu_result  <= '0;
            pend_wd_q       <= 1'b0;
            pend_alu_q      <= '0;
            skid_valid_q    <= 1'b0;
            skid_wd_q       <= 1'b0;
            skid_alu_q      <= '0;
        end else begin
            state_q         <= state_d;
            mem_req         <= mem_req_d;
            mem_we          <= mem_we_d;
            mem_addr        <= mem_addr_d;
            mem_wdata       <= mem_wdata_d;
            out_valid       <= out_valid_d;
            out_wd_selector <= out_wd_d;
            out_read_data   <= out_rd_d;
            out_alu_result  <= out_alu_d;
            pend_wd_q       <= pend_wd_d;
            pend_alu_q      <= pend_alu_d;
            skid_valid_q    <= skid_valid_d;
            skid_wd_q       <= skid_wd_d;
            skid_alu_q      <= skid_alu_d;
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage. It sits between the execute stage and the write-back stage.
- Takes the ALU result and load/store control from execute and runs a req/ack handshake with a variable-latency data memory.
- Delivers registered read_data, alu_result and wd_selector to write-back with a valid flag.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- N, 32, datapath and address width in bits.
- TIMEOUT, 64, watchdog limit in cycles; used only when MEM_STAGE_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low (rst==0 resets on the next rising clk edge).
- in_valid  input  1  execute stage presents an instruction.
- in_mem_read  input  1  instruction is a load.
- in_mem_write  input  1  instruction is a store.
- in_wd_selector  input  1  write-back select: 1=ALU result, 0=memory data.
- in_alu_result  input  N  ALU result; also the byte address for loads/stores.
- in_write_data  input  N  store data.
- stall  output  1  upstream must hold its inputs.
- mem_req  output  1  memory request.
- mem_we  output  1  1=write, 0=read; valid while mem_req=1.
- mem_addr  output  N  word-aligned address.
- mem_wdata  output  N  store data.
- mem_ack  input  1  memory completes the request in this cycle.
- mem_rdata  input  N  load data; valid when mem_ack=1 and mem_we=0.
- out_valid  output  1  write-back inputs valid this cycle.
- out_wd_selector  output  1  registered wd_selector.
- out_read_data  output  N  registered load data.
- out_alu_result  output  N  registered ALU result.
- err  output  1  sticky watchdog error flag.

Behaviour:
- States: IDLE, BUSY.
- Reset values: state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; out_valid=0, out_wd_selector=0, out_read_data=0, out_alu_result=0; err=0.
- Accept condition: in_valid && (state==IDLE || (state==BUSY && mem_ack)).
- Non-memory instruction (both in_mem_read and in_mem_write =0), accepted at edge T:
  - out_valid=1 and outputs captured from the inputs after edge T (latency 1).
  - out_read_data holds its previous value.
- Memory instruction accepted at edge T:
  - state→BUSY; mem_req=1 from after edge T.
  - mem_addr = {in_alu_result[N-1:2], 2'b00}; mem_wdata = in_write_data.
  - mem_we = in_mem_write.
  - out_valid=0 until completion.
- in_mem_read and in_mem_write both set: treated as a store (write priority).
- stall = (state==BUSY) && !mem_ack. It is combinational, so it is deasserted in the ack cycle.
- BUSY with mem_ack=1:
  - Load: out_read_data ← mem_rdata. For both loads and stores, out_alu_result and out_wd_selector ← the values captured at accept.
  - out_valid=1 for exactly the following cycle.
  - mem_req drops unless a new memory instruction is accepted in the same cycle; in that case mem_req stays 1 with the new addr/we/wdata (back-to-back, no idle bubble).
- out_valid is a 1-cycle pulse per completed instruction. Write-back always accepts; there is no downstream backpressure.
- mem_req, mem_we, mem_addr and mem_wdata are stable while BUSY and not acked.
- The memory must not assert mem_ack when mem_req=0; any such ack is ignored.
- Reset mid-transaction: state→IDLE, mem_req→0, out_valid→0. A later ack is ignored.
- in_valid=0 in IDLE: out_valid=0; all other registers hold.

Optional Feature:
- Macro: MEM_STAGE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT: abort the transaction, state→IDLE, mem_req→0.
  - Emit out_valid=1 with out_read_data=0, and set err=1 (sticky until reset).
- Undefined: no counter; BUSY waits indefinitely; err is tied 0.

Decomposition:
- Shared package mem_pkg:
  - state enum mem_state_t {IDLE, BUSY}.
  - Localparam ADDR_ALIGN_BITS=2.
- Sub-module mem_stage_wdog (timeout counter), instantiated only under MEM_STAGE_TIMEOUT_EN.

Test Plan:
- Reset: rst=0 for 2 cycles with in_valid=1 → all outputs 0, mem_req=0.
- ALU op: in_valid=1, alu_result=0x0000_0010, wd_selector=1 → next cycle out_valid=1, out_alu_result=0x10, stall=0, mem_req=0.
- Load with 3-cycle ack: alu_result=0x0000_0107 → mem_addr=0x104, mem_we=0; stall=1 for 2 cycles and 0 in the ack cycle; mem_rdata=0xDEAD_BEEF → next cycle out_valid=1, out_read_data=0xDEADBEEF, out_wd_selector=0.
- Back-to-back: store (addr 0x20, wdata 0x55) then load (addr 0x24), each acked after 1 cycle → mem_req stays 1 across the boundary, mem_we 1→0, exactly two out_valid pulses.
- Reset mid-load: assert rst=0 while BUSY, then ack arrives → state IDLE, no out_valid, out_read_data unchanged at 0.
- With MEM_STAGE_TIMEOUT_EN, TIMEOUT=4: load never acked → after 4 BUSY cycles mem_req=0, out_valid=1 with out_read_data=0, err=1 held until reset.
